// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: load-type encodings, special register
// numbers and the writeback stage state type.
package mips_pkg;

  localparam int ALIGN_W = 32;

  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LH  = 3'd1;
  localparam logic [2:0] LT_LHU = 3'd2;
  localparam logic [2:0] LT_LB  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;

  localparam logic [4:0] REG_RA   = 5'd31;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_WRITE    = 2'd2
  } stage_state_t;

endpackage

// File: rtl/load_align.sv
// Big-endian load alignment and extension of a raw memory word.
// Purely combinational so the forwarding unit can share it.
module load_align
  import mips_pkg::*;
(
  input  logic [ALIGN_W-1:0] i_rdata,
  input  logic [1:0]         i_off,
  input  logic [2:0]         i_load_type,
  output logic [ALIGN_W-1:0] o_data
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  always_comb begin
    // Lowest address holds the most significant bits.
    w_half = i_off[1] ? i_rdata[15:0] : i_rdata[31:16];
    case (i_off)
      2'd0:    w_byte = i_rdata[31:24];
      2'd1:    w_byte = i_rdata[23:16];
      2'd2:    w_byte = i_rdata[15:8];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  always_comb begin
    case (i_load_type)
      LT_LH:   o_data = {{16{w_half[15]}}, w_half};
      LT_LHU:  o_data = {16'h0000, w_half};
      LT_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      LT_LBU:  o_data = {24'h000000, w_byte};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MIPS writeback stage: accepts one retiring instruction, waits for load
// data if needed, and drives the register-file write port for one cycle.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_dst,
  input  logic              in_link,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic [2:0]        in_load_type,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_wn,
  output logic [DATA_W-1:0] wb_wd,
  output logic              fwd_valid,
  output logic              busy
);

  stage_state_t r_state, w_next;

  logic [REG_AW-1:0] r_wb_wn, r_pend_wn;
  logic [DATA_W-1:0] r_wb_wd;
  logic              r_wb_rw, r_pend_rw;
  logic [1:0]        r_pend_off;
  logic [2:0]        r_pend_lt;

  logic              w_accept, w_is_load;
  logic [REG_AW-1:0] w_wn_new;
  logic [DATA_W-1:0] w_wd_new, w_align;
  logic [1:0]        w_off_sel;
  logic [2:0]        w_lt_sel;

  assign w_accept  = in_valid & in_ready;
  assign w_is_load = in_mem_to_reg & ~in_link;
  assign w_wn_new  = in_link ? REG_AW'(REG_RA) : (in_reg_dst ? in_rd : in_rt);

  // While waiting, alignment uses the captured offset/type; otherwise the live inputs.
  assign w_off_sel = (r_state == ST_WAIT_MEM) ? r_pend_off : in_alu_result[1:0];
  assign w_lt_sel  = (r_state == ST_WAIT_MEM) ? r_pend_lt  : in_load_type;

  load_align u_load_align (
    .i_rdata     (mem_rdata),
    .i_off       (w_off_sel),
    .i_load_type (w_lt_sel),
    .o_data      (w_align)
  );

  always_comb begin
    if (in_link)
      w_wd_new = in_pc + DATA_W'(8);
    else if (!in_mem_to_reg)
      w_wd_new = in_alu_result;
    else
      w_wd_new = w_align;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= ST_EMPTY;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_WAIT_MEM: if (mem_rvalid) w_next = ST_WRITE;
      default: begin
        if (w_accept)
          w_next = (w_is_load && !mem_rvalid) ? ST_WAIT_MEM : ST_WRITE;
        else
          w_next = ST_EMPTY;
      end
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ST_EMPTY) || (r_state == ST_WRITE);
    busy      = (r_state != ST_EMPTY);
    wb_we     = (r_state == ST_WRITE) && r_wb_rw && (r_wb_wn != REG_AW'(REG_ZERO));
    fwd_valid = wb_we;
    wb_wn     = r_wb_wn;
    wb_wd     = r_wb_wd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_wn    <= '0;
      r_wb_wd    <= '0;
      r_wb_rw    <= 1'b0;
      r_pend_wn  <= '0;
      r_pend_rw  <= 1'b0;
      r_pend_off <= 2'd0;
      r_pend_lt  <= LT_LW;
    end else begin
      if (w_accept) begin
        r_pend_wn  <= w_wn_new;
        r_pend_rw  <= in_reg_write;
        r_pend_off <= in_alu_result[1:0];
        r_pend_lt  <= in_load_type;
      end
      // Visible write-port values change only when a result becomes final.
      if (w_next == ST_WRITE) begin
        if (r_state == ST_WAIT_MEM) begin
          r_wb_wn <= r_pend_wn;
          r_wb_rw <= r_pend_rw;
          r_wb_wd <= w_align;
        end else begin
          r_wb_wn <= w_wn_new;
          r_wb_rw <= in_reg_write;
          r_wb_wd <= w_wd_new;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: reset, ALU writes, loads, link,
// $0 suppression with back-to-back follow-up, and reset during a load wait.
module tb_mem_wb_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_alu_result, in_pc;
  logic [4:0]  in_rt, in_rd;
  logic        in_reg_dst, in_link, in_reg_write, in_mem_to_reg;
  logic [2:0]  in_load_type;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_we;
  logic [4:0]  wb_wn;
  logic [31:0] wb_wd;
  logic        fwd_valid, busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_pc(in_pc),
    .in_rt(in_rt), .in_rd(in_rd), .in_reg_dst(in_reg_dst),
    .in_link(in_link), .in_reg_write(in_reg_write),
    .in_mem_to_reg(in_mem_to_reg), .in_load_type(in_load_type),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_we(wb_we), .wb_wn(wb_wn), .wb_wd(wb_wd),
    .fwd_valid(fwd_valid), .busy(busy)
  );

  task automatic clear_inputs();
    in_valid = 0; in_alu_result = 0; in_pc = 0; in_rt = 0; in_rd = 0;
    in_reg_dst = 0; in_link = 0; in_reg_write = 0; in_mem_to_reg = 0;
    in_load_type = LT_LW; mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    step(); step();
    rst = 0;
    step();
    n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", wb_we); end
    n_checks++; if (wb_wn !== 5'd0) begin n_fail++; $display("FAIL reset_wn got=%0d exp=0", wb_wn); end
    n_checks++; if (wb_wd !== 32'd0) begin n_fail++; $display("FAIL reset_wd got=%h exp=0", wb_wd); end
    n_checks++; if (fwd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fwd got=%b exp=0", fwd_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    $display("reset: we=%b wn=%0d wd=%h ready=%b", wb_we, wb_wn, wb_wd, in_ready);
  endtask

  task automatic test_alu_write();
    clear_inputs();
    in_valid = 1; in_rd = 5; in_rt = 3; in_reg_dst = 1; in_reg_write = 1;
    in_alu_result = 32'h0000_1234;
    step();
    in_valid = 0;
    n_checks++; if (wb_we !== 1'b1) begin n_fail++; $display("FAIL add_we got=%b exp=1", wb_we); end
    n_checks++; if (wb_wn !== 5'd5) begin n_fail++; $display("FAIL add_wn got=%0d exp=5", wb_wn); end
    n_checks++; if (wb_wd !== 32'h0000_1234) begin n_fail++; $display("FAIL add_wd got=%h exp=00001234", wb_wd); end
    n_checks++; if (fwd_valid !== 1'b1) begin n_fail++; $display("FAIL add_fwd got=%b exp=1", fwd_valid); end
    $display("add: we=%b wn=%0d wd=%h", wb_we, wb_wn, wb_wd);
    step();
    n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL add_we_drop got=%b exp=0", wb_we); end
    n_checks++; if (wb_wn !== 5'd5) begin n_fail++; $display("FAIL add_wn_hold got=%0d exp=5", wb_wn); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL add_busy got=%b exp=0", busy); end
  endtask

  // delay 0: rvalid in the accept cycle; delay k: rvalid captured k edges after accept.
  task automatic test_load(input string name, input logic [2:0] lt, input logic [1:0] off,
                           input logic [31:0] data, input int delay, input logic [31:0] exp);
    clear_inputs();
    in_valid = 1; in_mem_to_reg = 1; in_reg_write = 1; in_rt = 9; in_rd = 2;
    in_load_type = lt; in_alu_result = {30'h0400_0000, off};
    if (delay == 0) begin
      mem_rvalid = 1; mem_rdata = data;
    end else begin
      mem_rdata = 32'hDEAD_BEEF;
    end
    step();
    in_valid = 0;
    mem_rvalid = 0;
    if (delay > 0) begin
      for (int i = 0; i < delay - 1; i++) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL %s_wait_ready got=%b exp=0", name, in_ready); end
        n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL %s_wait_we got=%b exp=0", name, wb_we); end
        step();
      end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_wait_busy got=%b exp=1", name, busy); end
      mem_rvalid = 1; mem_rdata = data;
      step();
      mem_rvalid = 0; mem_rdata = 32'hDEAD_BEEF;
    end
    n_checks++; if (wb_we !== 1'b1) begin n_fail++; $display("FAIL %s_we got=%b exp=1", name, wb_we); end
    n_checks++; if (wb_wn !== 5'd9) begin n_fail++; $display("FAIL %s_wn got=%0d exp=9", name, wb_wn); end
    n_checks++; if (wb_wd !== exp) begin n_fail++; $display("FAIL %s_wd got=%h exp=%h", name, wb_wd, exp); end
    $display("%s: off=%0d data=%h wd=%h exp=%h", name, off, data, wb_wd, exp);
    step();
    n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL %s_we_drop got=%b exp=0", name, wb_we); end
  endtask

  task automatic test_link();
    clear_inputs();
    in_valid = 1; in_link = 1; in_reg_write = 1; in_reg_dst = 1; in_rd = 5;
    in_mem_to_reg = 1; in_pc = 32'h0040_0010; in_alu_result = 32'h1111_1111;
    step();
    in_valid = 0;
    n_checks++; if (wb_we !== 1'b1) begin n_fail++; $display("FAIL jal_we got=%b exp=1", wb_we); end
    n_checks++; if (wb_wn !== 5'd31) begin n_fail++; $display("FAIL jal_wn got=%0d exp=31", wb_wn); end
    n_checks++; if (wb_wd !== 32'h0040_0018) begin n_fail++; $display("FAIL jal_wd got=%h exp=00400018", wb_wd); end
    $display("jal: we=%b wn=%0d wd=%h", wb_we, wb_wn, wb_wd);
    step();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    in_valid = 1; in_rt = 0; in_reg_dst = 0; in_reg_write = 1; in_alu_result = 32'h0000_00AA;
    step();
    n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL zero_we got=%b exp=0", wb_we); end
    n_checks++; if (wb_wd !== 32'h0000_00AA) begin n_fail++; $display("FAIL zero_wd got=%h exp=000000aa", wb_wd); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy got=%b exp=1", busy); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready got=%b exp=1", in_ready); end
    $display("zero: we=%b wn=%0d wd=%h", wb_we, wb_wn, wb_wd);
    in_rd = 7; in_reg_dst = 1; in_alu_result = 32'h0000_0077;
    step();
    in_valid = 0;
    n_checks++; if (wb_we !== 1'b1) begin n_fail++; $display("FAIL b2b_we got=%b exp=1", wb_we); end
    n_checks++; if (wb_wn !== 5'd7) begin n_fail++; $display("FAIL b2b_wn got=%0d exp=7", wb_wn); end
    n_checks++; if (wb_wd !== 32'h0000_0077) begin n_fail++; $display("FAIL b2b_wd got=%h exp=00000077", wb_wd); end
    $display("b2b: we=%b wn=%0d wd=%h", wb_we, wb_wn, wb_wd);
    step();
  endtask

  task automatic test_reset_in_wait();
    clear_inputs();
    in_valid = 1; in_mem_to_reg = 1; in_reg_write = 1; in_rt = 12; in_load_type = LT_LW;
    step();
    in_valid = 0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstw_pre_busy got=%b exp=1", busy); end
    rst = 1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstw_busy got=%b exp=0", busy); end
    n_checks++; if (wb_wn !== 5'd0) begin n_fail++; $display("FAIL rstw_wn got=%0d exp=0", wb_wn); end
    n_checks++; if (wb_wd !== 32'd0) begin n_fail++; $display("FAIL rstw_wd got=%h exp=0", wb_wd); end
    step();
    rst = 0;
    mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
    step();
    mem_rvalid = 0;
    n_checks++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL rstw_we got=%b exp=0", wb_we); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstw_busy2 got=%b exp=0", busy); end
    n_checks++; if (wb_wd !== 32'd0) begin n_fail++; $display("FAIL rstw_wd2 got=%h exp=0", wb_wd); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstw_ready got=%b exp=1", in_ready); end
    $display("reset_in_wait: we=%b busy=%b wn=%0d wd=%h", wb_we, busy, wb_wn, wb_wd);
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_alu_write();
    test_load("lb",  LT_LB,  2'd1, 32'h11F2_3344, 3, 32'hFFFF_FFF2);
    test_load("lbu", LT_LBU, 2'd1, 32'h11F2_3344, 3, 32'h0000_00F2);
    test_load("lh",  LT_LH,  2'd2, 32'h1234_8001, 0, 32'hFFFF_8001);
    test_load("lhu", LT_LHU, 2'd2, 32'h1234_8001, 0, 32'h0000_8001);
    test_load("lb3", LT_LB,  2'd3, 32'h11F2_3384, 1, 32'hFFFF_FF84);
    test_load("lw",  LT_LW,  2'd2, 32'h89AB_CDEF, 2, 32'h89AB_CDEF);
    test_load("lh0", LT_LH,  2'd1, 32'h8765_4321, 0, 32'hFFFF_8765);
    test_link();
    test_back_to_back();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
